deserializer: RTL and testbench

//  Collects N_SAMPLES words arriving one per val/rdy handshake and presents them

---
 rtl/deserializer_pkg.sv | 13 +
 rtl/deserializer_ctrl.sv | 90 +++++++++
 rtl/deserializer.sv | 51 +++++
 tb/tb_deserializer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/deserializer_pkg.sv
// Shared types and helpers for the word-serial to frame-parallel deserializer.
package deserializer_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_e;

    function automatic int unsigned CNT_W(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/deserializer_ctrl.sv
// Frame-assembly FSM: tracks the sample slot and produces handshakes and the
// one-hot write enable for the sample registers.
module deserializer_ctrl
    import deserializer_pkg::*;
#(
    parameter int unsigned N_SAMPLES = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 recv_val_i,
    input  logic                 send_rdy_i,
    output logic                 recv_rdy_o,
    output logic                 send_val_o,
    output logic [N_SAMPLES-1:0] reg_we_o,
    output state_e               state_o
);

    localparam int unsigned CW = CNT_W(N_SAMPLES);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            recv_fire;
    logic            send_fire;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= COLLECT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Ready is gated by reset so nothing can be accepted while it is held.
    always_comb begin
        recv_rdy_o = 1'b0;
        send_val_o = 1'b0;
        case (state_q)
            COLLECT: recv_rdy_o = rst_ni;
            HOLD: begin
                send_val_o = 1'b1;
                recv_rdy_o = send_rdy_i;
            end
            default: ;
        endcase
    end

    assign recv_fire = recv_val_i & recv_rdy_o;
    assign send_fire = send_val_o & send_rdy_i;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        reg_we_o = '0;
        case (state_q)
            COLLECT: begin
                if (recv_fire) begin
                    reg_we_o[cnt_q] = 1'b1;
                    if (cnt_q == CW'(N_SAMPLES - 1)) begin
                        cnt_d   = '0;
                        state_d = HOLD;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (send_fire) begin
                    if (recv_fire) begin
                        // Frame handed off and next frame's first word captured on the same edge.
                        reg_we_o[0] = 1'b1;
                        if (N_SAMPLES == 1) begin
                            state_d = HOLD;
                        end else begin
                            cnt_d   = CW'(1);
                            state_d = COLLECT;
                        end
                    end else begin
                        state_d = COLLECT;
                    end
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    assign state_o = state_q;

endmodule

// File: rtl/deserializer.sv
// Collects N_SAMPLES handshaken words and presents them as one parallel frame;
// send_msg[i] is the i-th word received.
module deserializer
    import deserializer_pkg::*;
#(
    parameter int unsigned BIT_WIDTH = 32,
    parameter int unsigned N_SAMPLES = 8
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [BIT_WIDTH-1:0]                 recv_msg,
    input  logic                                 recv_val,
    output logic                                 recv_rdy,
    output logic [N_SAMPLES-1:0][BIT_WIDTH-1:0]  send_msg,
    output logic                                 send_val,
    input  logic                                 send_rdy
);

    logic [N_SAMPLES-1:0]                 reg_we;
    state_e                               ctrl_state;
    logic [N_SAMPLES-1:0][BIT_WIDTH-1:0]  sample_q;

    deserializer_ctrl #(
        .N_SAMPLES (N_SAMPLES)
    ) u_ctrl (
        .clk_i      (clk),
        .rst_ni     (reset),
        .recv_val_i (recv_val),
        .send_rdy_i (send_rdy),
        .recv_rdy_o (recv_rdy),
        .send_val_o (send_val),
        .reg_we_o   (reg_we),
        .state_o    (ctrl_state)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sample_q <= '0;
        end else begin
            for (int unsigned i = 0; i < N_SAMPLES; i++) begin
                if (reg_we[i]) sample_q[i] <= recv_msg;
            end
        end
    end

    assign send_msg = sample_q;

    a_val_tracks_hold: assert property (@(posedge clk) disable iff (!reset)
        send_val == (ctrl_state == HOLD));

endmodule

// File: tb/tb_deserializer.sv
module tb_deserializer;

    typedef logic [7:0][31:0] frame_t;

    logic        clk = 1'b0;
    logic        reset;

    logic [31:0] recv_msg0;
    logic        recv_val0, recv_rdy0, send_val0, send_rdy0;
    frame_t      send_msg0;

    logic [31:0]      recv_msg1;
    logic             recv_val1, recv_rdy1, send_val1, send_rdy1;
    logic [0:0][31:0] send_msg1;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: pending words, held frame and a log of frames the DUT handed off.
    logic [31:0] pend0[$];
    frame_t      frame0;
    bit          full0;
    frame_t      dut_taken0[$];
    logic [31:0] frame1;
    bit          full1;

    deserializer #(.BIT_WIDTH(32), .N_SAMPLES(8)) dut0 (
        .clk(clk), .reset(reset), .recv_msg(recv_msg0), .recv_val(recv_val0),
        .recv_rdy(recv_rdy0), .send_msg(send_msg0), .send_val(send_val0), .send_rdy(send_rdy0)
    );

    deserializer #(.BIT_WIDTH(32), .N_SAMPLES(1)) dut1 (
        .clk(clk), .reset(reset), .recv_msg(recv_msg1), .recv_val(recv_val1),
        .recv_rdy(recv_rdy1), .send_msg(send_msg1), .send_val(send_val1), .send_rdy(send_rdy1)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    // Advance one clock, updating the model from the inputs presented before the edge.
    task automatic step();
        bit rf, sf;
        if (send_val0 && send_rdy0) dut_taken0.push_back(send_msg0);
        if (!reset) begin
            pend0.delete();
            full0 = 1'b0;
            full1 = 1'b0;
        end else begin
            sf = full0 && send_rdy0;
            rf = recv_val0 && (!full0 || send_rdy0);
            if (sf) full0 = 1'b0;
            if (rf) begin
                pend0.push_back(recv_msg0);
                if (pend0.size() == 8) begin
                    for (int i = 0; i < 8; i++) frame0[i] = pend0[i];
                    full0 = 1'b1;
                    pend0.delete();
                end
            end
            sf = full1 && send_rdy1;
            rf = recv_val1 && (!full1 || send_rdy1);
            if (sf) full1 = 1'b0;
            if (rf) begin
                frame1 = recv_msg1;
                full1  = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        recv_val0 = 1'b1; recv_msg0 = 32'hDEAD_BEEF; send_rdy0 = 1'b0;
        recv_val1 = 1'b0; recv_msg1 = '0; send_rdy1 = 1'b0;
        repeat (3) step();
        n_total++;
        if (recv_rdy0 !== 1'b0) $display("FAIL reset_rdy got %b required 0", recv_rdy0);
        else n_pass++;
        n_total++;
        if (send_val0 !== 1'b0) $display("FAIL reset_val got %b required 0", send_val0);
        else n_pass++;
        n_total++;
        if (send_msg0 !== '0) $display("FAIL reset_msg got %h required 0", send_msg0);
        else n_pass++;
        reset = 1'b1;
        recv_val0 = 1'b0;
        step();
        n_total++;
        if (recv_rdy0 !== 1'b1 || send_val0 !== 1'b0)
            $display("FAIL reset_release got rdy=%b val=%b required rdy=1 val=0", recv_rdy0, send_val0);
        else n_pass++;
    endtask

    task automatic test_basic();
        send_rdy0 = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            recv_val0 = 1'b1; recv_msg0 = 32'(i);
            step();
        end
        recv_val0 = 1'b0;
        n_total++;
        if (send_val0 !== 1'b1 || recv_rdy0 !== 1'b0)
            $display("FAIL basic_hs got val=%b rdy=%b required val=1 rdy=0", send_val0, recv_rdy0);
        else n_pass++;
        for (int i = 0; i < 8; i++) begin
            n_total++;
            if (send_msg0[i] !== 32'(i + 1))
                $display("FAIL basic_word%0d got %h required %h", i, send_msg0[i], 32'(i + 1));
            else n_pass++;
        end
        for (int c = 0; c < 5; c++) begin
            recv_val0 = 1'($urandom_range(0, 1)); recv_msg0 = $urandom;
            step();
            n_total++;
            if (send_val0 !== 1'b1 || send_msg0 !== frame0)
                $display("FAIL basic_hold c=%0d got val=%b msg=%h required val=1 msg=%h",
                         c, send_val0, send_msg0, frame0);
            else n_pass++;
        end
        recv_val0 = 1'b0; send_rdy0 = 1'b1;
        step();
        send_rdy0 = 1'b0;
        #1;
        n_total++;
        if (send_val0 !== 1'b0 || recv_rdy0 !== 1'b1)
            $display("FAIL basic_take got val=%b rdy=%b required val=0 rdy=1", send_val0, recv_rdy0);
        else n_pass++;
    endtask

    task automatic test_streaming();
        int base;
        dut_taken0.delete();
        base = 0;
        recv_val0 = 1'b1; send_rdy0 = 1'b1;
        for (int i = 0; i < 25; i++) begin
            recv_val0 = (i < 24);
            recv_msg0 = 32'(i);
            step();
            n_total++;
            if (recv_rdy0 !== 1'(!full0 || send_rdy0) || send_val0 !== full0 ||
                (full0 && send_msg0 !== frame0))
                $display("FAIL stream_cyc%0d got rdy=%b val=%b msg=%h required rdy=%b val=%b msg=%h",
                         i, recv_rdy0, send_val0, send_msg0, 1'(!full0 || send_rdy0), full0, frame0);
            else n_pass++;
        end
        recv_val0 = 1'b0; send_rdy0 = 1'b0;
        n_total++;
        if (dut_taken0.size() != 3) $display("FAIL stream_count got %0d required 3", dut_taken0.size());
        else n_pass++;
        for (int f = 0; f < 3 && f < dut_taken0.size(); f++) begin
            for (int w = 0; w < 8; w++) begin
                n_total++;
                if (dut_taken0[f][w] !== 32'(base + f * 8 + w))
                    $display("FAIL stream_f%0dw%0d got %h required %h", f, w, dut_taken0[f][w],
                             32'(base + f * 8 + w));
                else n_pass++;
            end
        end
    endtask

    task automatic test_bubbles();
        logic [31:0] sent[$];
        int cyc;
        dut_taken0.delete();
        cyc = 0;
        while ((sent.size() < 16 || full0) && cyc < 400) begin
            recv_val0 = (sent.size() < 16) ? 1'($urandom_range(0, 2) != 0) : 1'b0;
            recv_msg0 = $urandom;
            send_rdy0 = 1'($urandom_range(0, 1));
            #1;
            if (recv_val0 && recv_rdy0) sent.push_back(recv_msg0);
            step();
            cyc++;
            n_total++;
            if (recv_rdy0 !== 1'(!full0 || send_rdy0) || send_val0 !== full0 ||
                (full0 && send_msg0 !== frame0))
                $display("FAIL bubble_cyc%0d got rdy=%b val=%b required rdy=%b val=%b",
                         cyc, recv_rdy0, send_val0, 1'(!full0 || send_rdy0), full0);
            else n_pass++;
        end
        recv_val0 = 1'b0; send_rdy0 = 1'b0;
        n_total++;
        if (cyc >= 400 || dut_taken0.size() != 2)
            $display("FAIL bubble_frames got %0d frames in %0d cycles required 2", dut_taken0.size(), cyc);
        else n_pass++;
        for (int f = 0; f < 2 && f < dut_taken0.size(); f++) begin
            for (int w = 0; w < 8; w++) begin
                n_total++;
                if (dut_taken0[f][w] !== sent[f * 8 + w])
                    $display("FAIL bubble_f%0dw%0d got %h required %h", f, w, dut_taken0[f][w], sent[f * 8 + w]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] words[8];
        send_rdy0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            recv_val0 = 1'b1; recv_msg0 = 32'hA000_0000 + 32'(i);
            step();
        end
        recv_val0 = 1'b0;
        reset = 1'b0;
        step();
        n_total++;
        if (recv_rdy0 !== 1'b0 || send_val0 !== 1'b0 || send_msg0 !== '0)
            $display("FAIL midreset_state got rdy=%b val=%b msg=%h required 0/0/0", recv_rdy0, send_val0, send_msg0);
        else n_pass++;
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            words[i] = $urandom;
            recv_val0 = 1'b1; recv_msg0 = words[i];
            step();
            n_total++;
            if (send_val0 !== 1'(i == 7))
                $display("FAIL midreset_val%0d got %b required %b", i, send_val0, 1'(i == 7));
            else n_pass++;
        end
        recv_val0 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_total++;
            if (send_msg0[i] !== words[i])
                $display("FAIL midreset_word%0d got %h required %h", i, send_msg0[i], words[i]);
            else n_pass++;
        end
        send_rdy0 = 1'b1;
        step();
        send_rdy0 = 1'b0;
    endtask

    task automatic test_n1();
        logic [31:0] w;
        recv_val1 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            recv_msg1 = $urandom;
            send_rdy1 = 1'(i % 2);
            step();
            n_total++;
            if (recv_rdy1 !== 1'(!full1 || send_rdy1) || send_val1 !== full1 ||
                (full1 && send_msg1[0] !== frame1))
                $display("FAIL n1_cyc%0d got rdy=%b val=%b msg=%h required rdy=%b val=%b msg=%h",
                         i, recv_rdy1, send_val1, send_msg1[0], 1'(!full1 || send_rdy1), full1, frame1);
            else n_pass++;
        end
        // Held frame replaced on the same edge it is consumed.
        w = 32'h5A5A_1234;
        send_rdy1 = 1'b1; recv_msg1 = w; recv_val1 = 1'b1;
        step();
        n_total++;
        if (send_val1 !== 1'b1 || send_msg1[0] !== w)
            $display("FAIL n1_stream got val=%b msg=%h required val=1 msg=%h", send_val1, send_msg1[0], w);
        else n_pass++;
        recv_val1 = 1'b0; send_rdy1 = 1'b0;
        step();
    endtask

    initial begin
        full0 = 1'b0; full1 = 1'b0; frame0 = '0; frame1 = '0;
        test_reset();
        test_basic();
        test_streaming();
        test_bubbles();
        test_reset_mid();
        test_n1();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
